// File: rtl/phase_dev_meas.sv
// Phase deviation meter: per-window peak |phase| or half peak-to-peak, averaged over a
// group of windows. Two-stage result pipeline so sampling never stalls.
module phase_dev_meas #(
    parameter int unsigned PHASE_WIDTH = 32,
    parameter int unsigned WIN_LOG2    = 12,
    parameter int unsigned AVG_LOG2    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   in_valid,
    input  logic [PHASE_WIDTH-1:0] phase_in,
    input  logic                   mode,
    output logic [PHASE_WIDTH-1:0] dev_out,
    output logic                   dev_valid,
    output logic                   win_busy
);

    localparam int unsigned PW = PHASE_WIDTH;
    localparam int unsigned CW = (WIN_LOG2 > 0) ? WIN_LOG2 : 1;
    localparam int unsigned GW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned AW = PW + AVG_LOG2;

    localparam logic [CW-1:0] WinLast = (WIN_LOG2 > 0) ? {CW{1'b1}} : '0;
    localparam logic [GW-1:0] GrpLast = (AVG_LOG2 > 0) ? {GW{1'b1}} : '0;

    logic [CW-1:0]        win_cnt_q, win_cnt_d;
    logic [GW-1:0]        grp_cnt_q, grp_cnt_d;
    logic signed [PW-1:0] max_q, max_d, min_q, min_d;
    logic                 mode_q, mode_d;
    logic                 busy_q, busy_d;
    logic                 close_q, close_d;
    logic                 close_mode_q, close_mode_d;
    logic                 close_last_q, close_last_d;
    logic [PW-1:0]        res_q, res_d;
    logic                 res_vld_q, res_vld_d;
    logic                 res_last_q, res_last_d;
    logic [AW-1:0]        acc_q, acc_d;
    logic [PW-1:0]        dev_q, dev_d;
    logic                 dev_vld_q, dev_vld_d;

    logic signed [PW-1:0] phase_s;
    logic                 win_first, win_close, grp_first, grp_close, mode_eff;
    logic [PW-1:0]        max_mag, min_mag, peak_mag;
    logic [PW:0]          diff;
    logic [AW-1:0]        acc_sum;

    assign phase_s   = phase_in;
    assign win_first = (win_cnt_q == '0);
    assign win_close = (win_cnt_q == WinLast);
    assign grp_first = (grp_cnt_q == '0);
    assign grp_close = (grp_cnt_q == GrpLast);
    // Mode is sampled only on the very first sample of a group.
    assign mode_eff  = (win_first && grp_first) ? mode : mode_q;

    // Window collection: counter, running extremes, latched mode, busy flag.
    always_comb begin
        win_cnt_d    = win_cnt_q;
        grp_cnt_d    = grp_cnt_q;
        max_d        = max_q;
        min_d        = min_q;
        mode_d       = mode_q;
        busy_d       = busy_q;
        close_d      = 1'b0;
        close_mode_d = close_mode_q;
        close_last_d = close_last_q;
        if (clear) begin
            win_cnt_d = '0;
            grp_cnt_d = '0;
            busy_d    = 1'b0;
        end else if (in_valid) begin
            win_cnt_d = win_close ? '0 : win_cnt_q + CW'(1);
            max_d     = (win_first || phase_s > max_q) ? phase_s : max_q;
            min_d     = (win_first || phase_s < min_q) ? phase_s : min_q;
            mode_d    = mode_eff;
            busy_d    = !win_close;
            if (win_close) begin
                close_d      = 1'b1;
                close_mode_d = mode_eff;
                close_last_d = grp_close;
                grp_cnt_d    = grp_close ? '0 : grp_cnt_q + GW'(1);
            end
        end
    end

    // Stage 1: window result from the closed window's extremes.
    always_comb begin
        max_mag  = max_q[PW-1] ? (~max_q + PW'(1)) : max_q;
        min_mag  = min_q[PW-1] ? (~min_q + PW'(1)) : min_q;
        peak_mag = (max_mag > min_mag) ? max_mag : min_mag;
        diff     = {max_q[PW-1], max_q} - {min_q[PW-1], min_q};
        res_d      = close_q ? (close_mode_q ? diff[PW:1] : peak_mag) : res_q;
        res_vld_d  = close_q && !clear;
        res_last_d = close_last_q;
    end

    // Stage 2: accumulate and emit the group mean.
    always_comb begin
        acc_sum   = acc_q + AW'(res_q);
        acc_d     = acc_q;
        dev_d     = dev_q;
        dev_vld_d = 1'b0;
        if (clear) begin
            acc_d = '0;
        end else if (res_vld_q) begin
            if (res_last_q) begin
                dev_d     = PW'(acc_sum >> AVG_LOG2);
                dev_vld_d = 1'b1;
                acc_d     = '0;
            end else begin
                acc_d = acc_sum;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_cnt_q    <= '0;
            grp_cnt_q    <= '0;
            max_q        <= '0;
            min_q        <= '0;
            mode_q       <= 1'b0;
            busy_q       <= 1'b0;
            close_q      <= 1'b0;
            close_mode_q <= 1'b0;
            close_last_q <= 1'b0;
            res_q        <= '0;
            res_vld_q    <= 1'b0;
            res_last_q   <= 1'b0;
            acc_q        <= '0;
            dev_q        <= '0;
            dev_vld_q    <= 1'b0;
        end else begin
            win_cnt_q    <= win_cnt_d;
            grp_cnt_q    <= grp_cnt_d;
            max_q        <= max_d;
            min_q        <= min_d;
            mode_q       <= mode_d;
            busy_q       <= busy_d;
            close_q      <= close_d;
            close_mode_q <= close_mode_d;
            close_last_q <= close_last_d;
            res_q        <= res_d;
            res_vld_q    <= res_vld_d;
            res_last_q   <= res_last_d;
            acc_q        <= acc_d;
            dev_q        <= dev_d;
            dev_vld_q    <= dev_vld_d;
        end
    end

    assign dev_out   = dev_q;
    assign dev_valid = dev_vld_q;
    assign win_busy  = busy_q;

endmodule

// File: tb/tb_phase_dev_meas.sv
// Bench for phase_dev_meas: directed group scenarios plus random traffic against a
// sample-list reference model of windows and groups.
module tb_phase_dev_meas;

    localparam int PW  = 16;
    localparam int WIN = 8;
    localparam int AVG = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic [PW-1:0] phase_in = '0;
    logic          mode = 1'b0;
    logic [PW-1:0] dev_out;
    logic          dev_valid;
    logic          win_busy;

    phase_dev_meas #(
        .PHASE_WIDTH(PW),
        .WIN_LOG2   (3),
        .AVG_LOG2   (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .in_valid (in_valid),
        .phase_in (phase_in),
        .mode     (mode),
        .dev_out  (dev_out),
        .dev_valid(dev_valid),
        .win_busy (win_busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int edge_n = 0;
    int obs_cyc[$];
    int obs_val[$];
    int exp_cyc[$];
    int exp_val[$];
    int win_q[$];
    int res_q[$];
    bit gmode = 1'b0;
    int pat[16];

    // Reference: keep the window's samples, reduce when full, average when group is full.
    function automatic void model_accept(int x, bit md);
        int mx, mn, amx, amn, r, s;
        if (win_q.size() == 0 && res_q.size() == 0) gmode = md;
        win_q.push_back(x);
        if (win_q.size() == WIN) begin
            mx = win_q[0];
            mn = win_q[0];
            foreach (win_q[i]) begin
                if (win_q[i] > mx) mx = win_q[i];
                if (win_q[i] < mn) mn = win_q[i];
            end
            amx = (mx < 0) ? -mx : mx;
            amn = (mn < 0) ? -mn : mn;
            r = gmode ? (mx - mn) / 2 : ((amx > amn) ? amx : amn);
            res_q.push_back(r);
            win_q.delete();
            if (res_q.size() == AVG) begin
                s = 0;
                foreach (res_q[i]) s += res_q[i];
                exp_cyc.push_back(edge_n + 2);
                exp_val.push_back(s / AVG);
                res_q.delete();
            end
        end
    endfunction

    function automatic void model_clear();
        int kc[$];
        int kv[$];
        win_q.delete();
        res_q.delete();
        foreach (exp_cyc[i]) begin
            if (exp_cyc[i] < edge_n) begin
                kc.push_back(exp_cyc[i]);
                kv.push_back(exp_val[i]);
            end
        end
        exp_cyc = kc;
        exp_val = kv;
    endfunction

    function automatic void model_reset();
        win_q.delete();
        res_q.delete();
        exp_cyc.delete();
        exp_val.delete();
    endfunction

    function automatic void flush_logs();
        obs_cyc.delete();
        obs_val.delete();
        exp_cyc.delete();
        exp_val.delete();
    endfunction

    // One clock edge with the given inputs; outputs observed 1 time unit after the edge.
    task automatic cyc(input bit v, input int ph, input bit md, input bit clr);
        in_valid = v;
        phase_in = PW'(ph);
        mode     = md;
        clear    = clr;
        @(posedge clk);
        edge_n++;
        if (clr) model_clear();
        else if (v) model_accept(ph, md);
        #1;
        if (dev_valid === 1'b1) begin
            obs_cyc.push_back(edge_n);
            obs_val.push_back(int'(dev_out));
        end
    endtask

    task automatic test_reset();
        #3;
        total++;
        if (dev_out !== '0) begin
            bad++;
            $display("FAIL reset_dev_out got=%0d want=0", dev_out);
        end
        total++;
        if (dev_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_dev_valid got=%b want=0", dev_valid);
        end
        total++;
        if (win_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_win_busy got=%b want=0", win_busy);
        end
        #4 rst = 1'b1;
    endtask

    // One full group of 16 accepted samples, with `gap` idle cycles before each sample.
    task automatic test_window_group(input string nm, input int vals[16], input bit md,
                                     input int gap, input int want);
        int e;
        flush_logs();
        for (int i = 0; i < 16; i++) begin
            for (int g = 0; g < gap; g++) cyc(1'b0, 12345, md, 1'b0);
            cyc(1'b1, vals[i], md, 1'b0);
            if (i == 0) begin
                total++;
                if (win_busy !== 1'b1) begin
                    bad++;
                    $display("FAIL %s_busy got=%b want=1", nm, win_busy);
                end
            end
        end
        e = edge_n;
        repeat (4) cyc(1'b0, 0, md, 1'b0);
        total++;
        if (obs_cyc.size() != 1) begin
            bad++;
            $display("FAIL %s_pulses got=%0d want=1", nm, obs_cyc.size());
        end else begin
            total++;
            if (obs_cyc[0] != e + 2) begin
                bad++;
                $display("FAIL %s_latency got=%0d want=%0d", nm, obs_cyc[0] - e, 2);
            end
            total++;
            if (obs_val[0] != want) begin
                bad++;
                $display("FAIL %s_pulse_val got=%0d want=%0d", nm, obs_val[0], want);
            end
        end
        total++;
        if (int'(dev_out) != want) begin
            bad++;
            $display("FAIL %s_hold got=%0d want=%0d", nm, dev_out, want);
        end
    endtask

    task automatic test_clear();
        int e;
        flush_logs();
        for (int i = 0; i < 5; i++) cyc(1'b1, 7000 - i * 900, 1'b0, 1'b0);
        total++;
        if (win_busy !== 1'b1) begin
            bad++;
            $display("FAIL clear_busy_before got=%b want=1", win_busy);
        end
        cyc(1'b1, 9999, 1'b0, 1'b1);
        total++;
        if (win_busy !== 1'b0 || dev_valid !== 1'b0) begin
            bad++;
            $display("FAIL clear_outputs got=%b%b want=00", win_busy, dev_valid);
        end
        for (int i = 0; i < 15; i++) cyc(1'b1, 200, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 0, 1'b0, 1'b0);
        total++;
        if (obs_cyc.size() != 0) begin
            bad++;
            $display("FAIL clear_early_pulse got=%0d want=0", obs_cyc.size());
        end
        cyc(1'b1, 200, 1'b0, 1'b0);
        e = edge_n;
        repeat (4) cyc(1'b0, 0, 1'b0, 1'b0);
        total++;
        if (obs_cyc.size() != 1) begin
            bad++;
            $display("FAIL clear_pulses got=%0d want=1", obs_cyc.size());
        end else begin
            total++;
            if (obs_cyc[0] != e + 2 || obs_val[0] != 200) begin
                bad++;
                $display("FAIL clear_result got=%0d@+%0d want=200@+2", obs_val[0], obs_cyc[0] - e);
            end
        end
    endtask

    task automatic test_rst_mid();
        int e;
        flush_logs();
        for (int i = 0; i < 16; i++) cyc(1'b1, 1000, 1'b0, 1'b0);
        repeat (4) cyc(1'b0, 0, 1'b0, 1'b0);
        total++;
        if (dev_out !== 16'd1000) begin
            bad++;
            $display("FAIL rst_pre_dev_out got=%0d want=1000", dev_out);
        end
        for (int i = 0; i < 3; i++) cyc(1'b1, 1000, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        total++;
        if (dev_out !== '0 || win_busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_async got=%0d/%b want=0/0", dev_out, win_busy);
        end
        model_reset();
        flush_logs();
        cyc(1'b0, 0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        for (int i = 0; i < 16; i++) cyc(1'b1, 50, 1'b0, 1'b0);
        e = edge_n;
        repeat (4) cyc(1'b0, 0, 1'b0, 1'b0);
        total++;
        if (obs_cyc.size() != 1) begin
            bad++;
            $display("FAIL rst_pulses got=%0d want=1", obs_cyc.size());
        end else begin
            total++;
            if (obs_cyc[0] != e + 2 || obs_val[0] != 50) begin
                bad++;
                $display("FAIL rst_result got=%0d@+%0d want=50@+2", obs_val[0], obs_cyc[0] - e);
            end
        end
    endtask

    // Two groups streamed without a gap; mode flips inside the first group.
    task automatic test_back_to_back();
        flush_logs();
        for (int i = 0; i < 32; i++)
            cyc(1'b1, int'($urandom_range(20000)) - 10000, (i >= 4), 1'b0);
        repeat (4) cyc(1'b0, 0, 1'b1, 1'b0);
        total++;
        if (obs_cyc.size() != exp_cyc.size() || obs_cyc.size() != 2) begin
            bad++;
            $display("FAIL b2b_pulses got=%0d want=2", obs_cyc.size());
        end else begin
            foreach (exp_cyc[i]) begin
                total++;
                if (obs_cyc[i] != exp_cyc[i] || obs_val[i] != exp_val[i]) begin
                    bad++;
                    $display("FAIL b2b_result[%0d] got=%0d@%0d want=%0d@%0d", i, obs_val[i],
                             obs_cyc[i], exp_val[i], exp_cyc[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        bit md;
        flush_logs();
        md = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(15) == 0) md = ~md;
            cyc(($urandom_range(9) < 7), int'($urandom_range(65535)) - 32768, md,
                ($urandom_range(199) == 0));
        end
        repeat (4) cyc(1'b0, 0, md, 1'b0);
        total++;
        if (obs_cyc.size() != exp_cyc.size()) begin
            bad++;
            $display("FAIL rand_pulses got=%0d want=%0d", obs_cyc.size(), exp_cyc.size());
        end else begin
            foreach (exp_cyc[i]) begin
                total++;
                if (obs_cyc[i] != exp_cyc[i] || obs_val[i] != exp_val[i]) begin
                    bad++;
                    $display("FAIL rand_result[%0d] got=%0d@%0d want=%0d@%0d", i, obs_val[i],
                             obs_cyc[i], exp_val[i], exp_cyc[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        foreach (pat[i]) pat[i] = 1000;
        test_window_group("const", pat, 1'b0, 0, 1000);
        foreach (pat[i]) pat[i] = (i % 2 == 1) ? -5000 : 3000;
        test_window_group("alt_peak", pat, 1'b0, 0, 5000);
        test_window_group("alt_p2p", pat, 1'b1, 0, 4000);
        foreach (pat[i]) pat[i] = (i % 8 == 5) ? -32768 : 0;
        test_window_group("min_neg", pat, 1'b0, 0, 32768);
        foreach (pat[i]) pat[i] = 1000;
        test_window_group("sparse", pat, 1'b0, 2, 1000);
        test_clear();
        test_rst_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/phase_dev_meas.md
PHASE_DEV_MEAS -- requirements
Module: phase_dev_meas

Interface
REQ-001 SHALL have parameter PHASE_WIDTH, default 32: bit width of the signed phase input and of the unsigned deviation output.
REQ-002 SHALL have parameter WIN_LOG2, default 12: the measurement window is 2^WIN_LOG2 accepted samples.
REQ-003 SHALL have parameter AVG_LOG2, default 2: the output is the mean of 2^AVG_LOG2 window results.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port clear, input, 1: synchronous restart of the measurement, active-high.
REQ-007 SHALL have port in_valid, input, 1: phase_in is accepted on a rising edge where in_valid=1.
REQ-008 SHALL have port phase_in, input, PHASE_WIDTH: signed two's-complement instantaneous phase from the PM demodulator.
REQ-009 SHALL have port mode, input, 1: 0 = peak |phase|; 1 = half peak-to-peak, (max-min)/2.
REQ-010 SHALL have port dev_out, output, PHASE_WIDTH: unsigned averaged phase deviation.
REQ-011 SHALL have port dev_valid, output, 1: one-cycle pulse marking a new dev_out.
REQ-012 SHALL have port win_busy, output, 1: high while a window holds at least one accepted sample.

Function
REQ-013 SHALL count accepted samples in a WIN_LOG2-bit window counter; cycles with in_valid=0 do not advance any state.
REQ-014 SHALL load both running max and running min from the first accepted sample of each window, ignoring values from earlier windows.
REQ-015 SHALL update running max and min with signed compares on each later accepted sample.
REQ-016 SHALL close the window on the accepted sample where the counter equals 2^WIN_LOG2-1, including that sample in max/min.
- The counter wraps to 0 on that edge.
REQ-017 SHALL, in mode 0, form the window result as max(|max|,|min|).
- Uses PHASE_WIDTH-bit unsigned magnitude; -2^(PHASE_WIDTH-1) gives 2^(PHASE_WIDTH-1) with no saturation.
REQ-018 SHALL, in mode 1, compute max-min at PHASE_WIDTH+1 bits, then shift right by 1 (floor) to give the window result.
REQ-019 SHALL latch mode at the first accepted sample of each averaging group.
- A mode change inside a group takes effect from the next group.
REQ-020 SHALL register the window result one edge after the closing edge (pipeline stage 1).
REQ-021 SHALL add each registered window result into a PHASE_WIDTH+AVG_LOG2-bit accumulator (stage 2).
REQ-022 SHALL, on stage 2 of the 2^AVG_LOG2-th window, load dev_out = (accumulator + that result) >> AVG_LOG2, pulse dev_valid, and zero the accumulator.
REQ-023 SHALL assert dev_valid exactly 2 rising edges after the edge that accepted the closing sample.
- dev_out holds its value until the next pulse.
REQ-024 SHALL continue accepting samples into the next window while stages 1-2 complete (no back-pressure, no dropped samples).
REQ-025 SHALL, on an edge with clear=1, zero the window counter, group counter, accumulator and pipeline valids, and discard any in_valid sample on that edge.
- dev_valid=0 on the following cycle; dev_out keeps its last value.
- Any window result in flight is discarded.
REQ-026 SHALL assert win_busy from the edge after the first accepted sample of a window until the closing edge, and deassert it on clear.

Reset
REQ-027 SHALL, while rst=0, immediately force dev_out=0, dev_valid=0, win_busy=0, all counters, max/min, accumulator and pipeline registers to 0, and latched mode to 0.
REQ-028 SHALL, after rst rises, treat the first accepted sample as the start of a new window and a new group.

Verification (PHASE_WIDTH=16, WIN_LOG2=3, AVG_LOG2=1)
REQ-029 SHALL cover: mode=0, 16 consecutive samples of +1000 -> a single dev_valid pulse 2 edges after sample 16, dev_out=1000.
REQ-030 SHALL cover: alternating +3000/-5000 for 16 samples -> dev_out=5000 with mode=0, and dev_out=4000 with mode=1.
REQ-031 SHALL cover: mode=0, one sample of -32768 in each window, others 0 -> dev_out=32768.
REQ-032 SHALL cover: the +1000 stream with in_valid high every third cycle -> dev_out=1000, and the pulse occurs 2 edges after the 16th accepted sample.
REQ-033 SHALL cover: clear after 5 samples, then 16 samples of +200 -> no pulse before the 16th post-clear sample, then dev_out=200.
REQ-034 SHALL cover: rst low mid-window after a prior dev_out=1000 -> dev_out=0 and win_busy=0 asynchronously; after release, 16 samples of +50 -> dev_out=50.
